fp_add_unit: RTL and testbench

//  Multicycle IEEE-754 single-precision add/sub execution unit for the datapath.

---
 rtl/fp_add_unit.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_fp_add_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_unit.sv
// fp_add_unit: multicycle IEEE-754 binary32 add/sub unit.
// Round-to-nearest-even; denormal inputs and results are flushed to signed zero.
// Fixed 5-cycle latency: IDLE -> UNPACK -> ALIGN -> ADDSUB -> NORM -> PACK -> IDLE.
// Ports:
//   clk               clock, all state on posedge
//   reset             asynchronous active-low reset
//   start, sub, a, b  request; captured only in IDLE (sub=1 selects a-b)
//   busy              operation in flight
//   done              one-cycle pulse, result/flags valid
//   result            packed result, held until the next done
//   overflow          finite inputs rounded to +/-Inf
//   invalid           NaN operand or Inf-Inf
module fp_add_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   invalid
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int M1  = MAN_W + 1;          // mantissa incl. hidden bit
    localparam int F   = MAN_W + 4;          // mantissa + guard/round/sticky
    localparam int LZW = $clog2(F + 1);
    localparam int XW  = EXP_W + 2;          // exponent with headroom for +1 and -lzc
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [XW-1:0]    EXP_INF  = XW'(2 * BIAS + 1);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_PACK
    } state_t;

    state_t state_q, state_d;

    // captured request
    logic [W-1:0]     a_q, b_q;
    logic             sub_q;
    // UNPACK stage
    logic             sa_q, sb_q;
    logic [EXP_W-1:0] ea_q, eb_q;
    logic [M1-1:0]    ma_q, mb_q;
    logic             spec_q, spec_inv_q;
    logic [W-1:0]     spec_res_q;
    // ALIGN stage
    logic             big_s_q, eff_sub_q;
    logic [EXP_W-1:0] big_e_q;
    logic [M1-1:0]    big_m_q;
    logic [F-1:0]     sml_m_q;
    // ADDSUB stage
    logic [F:0]       sum_q;
    logic             sum_s_q;
    logic [EXP_W-1:0] sum_e_q;
    // NORM stage
    logic [F-1:0]     nrm_m_q;
    logic [XW-1:0]    nrm_e_q;
    logic             nrm_s_q, nrm_z_q;

    //------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_UNPACK;
            S_UNPACK: state_d = S_ALIGN;
            S_ALIGN:  state_d = S_ADDSUB;
            S_ADDSUB: state_d = S_NORM;
            S_NORM:   state_d = S_PACK;
            S_PACK:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    //------------------------------------------------------------------
    // UNPACK: field split, zero flush, special-case classification
    //------------------------------------------------------------------
    logic [EXP_W-1:0] u_ea, u_eb;
    logic [MAN_W-1:0] u_fa, u_fb;
    logic             u_sa, u_sb;
    logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic [M1-1:0]    u_ma, u_mb;
    logic             u_spec, u_spec_inv;
    logic [W-1:0]     u_spec_res;

    always_comb begin
        u_ea   = a_q[W-2:MAN_W];
        u_eb   = b_q[W-2:MAN_W];
        u_fa   = a_q[MAN_W-1:0];
        u_fb   = b_q[MAN_W-1:0];
        u_sa   = a_q[W-1];
        u_sb   = b_q[W-1] ^ sub_q;
        a_zero = (u_ea == '0);
        b_zero = (u_eb == '0);
        a_nan  = (u_ea == EXP_ONES) && (u_fa != '0);
        b_nan  = (u_eb == EXP_ONES) && (u_fb != '0);
        a_inf  = (u_ea == EXP_ONES) && (u_fa == '0);
        b_inf  = (u_eb == EXP_ONES) && (u_fb == '0);
        u_ma   = a_zero ? '0 : {1'b1, u_fa};
        u_mb   = b_zero ? '0 : {1'b1, u_fb};

        u_spec     = 1'b0;
        u_spec_inv = 1'b0;
        u_spec_res = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (u_sa != u_sb))) begin
            u_spec     = 1'b1;
            u_spec_inv = 1'b1;
            u_spec_res = QNAN;
        end else if (a_inf) begin
            u_spec     = 1'b1;
            u_spec_res = {u_sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            u_spec     = 1'b1;
            u_spec_res = {u_sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    //------------------------------------------------------------------
    // ALIGN: order by magnitude, shift smaller operand with sticky
    //------------------------------------------------------------------
    logic             a_ge;
    logic             al_bs, al_ss;
    logic [EXP_W-1:0] al_be, al_se, al_diff;
    logic [M1-1:0]    al_bm, al_sm;
    logic [F-1:0]     al_ext, al_aligned;
    logic             al_lost;

    always_comb begin
        a_ge    = ({ea_q, ma_q} >= {eb_q, mb_q});
        al_bs   = a_ge ? sa_q : sb_q;
        al_ss   = a_ge ? sb_q : sa_q;
        al_be   = a_ge ? ea_q : eb_q;
        al_se   = a_ge ? eb_q : ea_q;
        al_bm   = a_ge ? ma_q : mb_q;
        al_sm   = a_ge ? mb_q : ma_q;
        al_diff = al_be - al_se;
        al_ext  = {al_sm, 3'b000};
        al_lost = 1'b0;
        if (32'(al_diff) >= F) begin
            al_aligned = {{(F-1){1'b0}}, |al_sm};
        end else begin
            // bits falling off the right end collapse into sticky
            al_lost    = |(al_ext & ~({F{1'b1}} << al_diff));
            al_aligned = (al_ext >> al_diff) | {{(F-1){1'b0}}, al_lost};
        end
    end

    //------------------------------------------------------------------
    // ADDSUB: magnitude ordering guarantees a non-negative difference
    //------------------------------------------------------------------
    logic [F:0] as_big, as_sml, as_sum;

    always_comb begin
        as_big = {1'b0, big_m_q, 3'b000};
        as_sml = {1'b0, sml_m_q};
        as_sum = eff_sub_q ? (as_big - as_sml) : (as_big + as_sml);
    end

    //------------------------------------------------------------------
    // NORM: one-step right shift on carry, else full left normalisation
    //------------------------------------------------------------------
    logic [LZW-1:0] lzc;
    logic [F-1:0]   nm_m;
    logic [XW-1:0]  nm_e;

    always_comb begin
        lzc = LZW'(F);
        for (int i = 0; i < F; i++) begin
            if (sum_q[i]) lzc = LZW'(F - 1 - i);
        end
        if (sum_q[F]) begin
            nm_m = {sum_q[F:2], sum_q[1] | sum_q[0]};
            nm_e = {2'b00, sum_e_q} + XW'(1);
        end else begin
            nm_m = sum_q[F-1:0] << lzc;
            nm_e = {2'b00, sum_e_q} - {{(XW-LZW){1'b0}}, lzc};
        end
    end

    //------------------------------------------------------------------
    // PACK: round-to-nearest-even and final special/overflow selection
    //------------------------------------------------------------------
    logic [M1-1:0]    pk_man;
    logic             pk_g, pk_r, pk_s, pk_rup;
    logic [M1:0]      pk_rnd;
    logic [XW-1:0]    pk_e;
    logic [MAN_W-1:0] pk_frac;
    logic [W-1:0]     pk_res;
    logic             pk_ovf, pk_inv;

    always_comb begin
        pk_man  = nrm_m_q[F-1:3];
        pk_g    = nrm_m_q[2];
        pk_r    = nrm_m_q[1];
        pk_s    = nrm_m_q[0];
        pk_rup  = pk_g & (pk_r | pk_s | pk_man[0]);
        pk_rnd  = {1'b0, pk_man} + {{M1{1'b0}}, pk_rup};
        pk_e    = nrm_e_q + {{(XW-1){1'b0}}, pk_rnd[M1]};
        pk_frac = pk_rnd[M1] ? pk_rnd[MAN_W:1] : pk_rnd[MAN_W-1:0];
        pk_ovf  = 1'b0;
        pk_inv  = 1'b0;
        if (spec_q) begin
            pk_res = spec_res_q;
            pk_inv = spec_inv_q;
        end else if (nrm_z_q || nrm_e_q[XW-1] || (nrm_e_q == '0)) begin
            // exact zero, or underflow below the normal range
            pk_res = {nrm_s_q, {(W-1){1'b0}}};
        end else if (pk_e >= EXP_INF) begin
            pk_res = {nrm_s_q, EXP_ONES, {MAN_W{1'b0}}};
            pk_ovf = 1'b1;
        end else begin
            pk_res = {nrm_s_q, pk_e[EXP_W-1:0], pk_frac};
        end
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ea_q       <= '0;
            eb_q       <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            spec_q     <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_res_q <= '0;
            big_s_q    <= 1'b0;
            eff_sub_q  <= 1'b0;
            big_e_q    <= '0;
            big_m_q    <= '0;
            sml_m_q    <= '0;
            sum_q      <= '0;
            sum_s_q    <= 1'b0;
            sum_e_q    <= '0;
            nrm_m_q    <= '0;
            nrm_e_q    <= '0;
            nrm_s_q    <= 1'b0;
            nrm_z_q    <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            invalid    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                    end
                end
                S_UNPACK: begin
                    sa_q       <= u_sa;
                    sb_q       <= u_sb;
                    ea_q       <= u_ea;
                    eb_q       <= u_eb;
                    ma_q       <= u_ma;
                    mb_q       <= u_mb;
                    spec_q     <= u_spec;
                    spec_inv_q <= u_spec_inv;
                    spec_res_q <= u_spec_res;
                end
                S_ALIGN: begin
                    big_s_q   <= al_bs;
                    eff_sub_q <= al_bs ^ al_ss;
                    big_e_q   <= al_be;
                    big_m_q   <= al_bm;
                    sml_m_q   <= al_aligned;
                end
                S_ADDSUB: begin
                    sum_q   <= as_sum;
                    sum_e_q <= big_e_q;
                    // x - x yields +0 regardless of operand signs
                    sum_s_q <= (eff_sub_q && (as_sum == '0)) ? 1'b0 : big_s_q;
                end
                S_NORM: begin
                    nrm_m_q <= nm_m;
                    nrm_e_q <= nm_e;
                    nrm_s_q <= sum_s_q;
                    nrm_z_q <= (sum_q == '0);
                end
                S_PACK: begin
                    result   <= pk_res;
                    overflow <= pk_ovf;
                    invalid  <= pk_inv;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_unit.sv
// Scoreboard bench for fp_add_unit: expectations are pushed when a request is
// driven and popped when done pulses; result, flags and latency are compared.
module tb_fp_add_unit;

    logic        clk, reset, start, sub;
    logic [31:0] a, b, result;
    logic        busy, done, overflow, invalid;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        inv;
        int          due;
    } exp_t;

    exp_t sb[$];

    fp_add_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard consumer
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                chk("invalid", {31'd0, invalid}, {31'd0, e.inv});
                chk("latency", 32'(cyc), 32'(e.due));
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Sets up a request; the next posedge captures it. done must be visible
    // at the negedge following the fifth edge after capture.
    task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                         input logic [31:0] er, input logic eo, input logic ei);
        exp_t e;
        start = 1'b1;
        a     = ta;
        b     = tb;
        sub   = ts;
        e.res = er;
        e.ovf = eo;
        e.inv = ei;
        e.due = cyc + 6;
        sb.push_back(e);
    endtask

    task automatic wait_empty(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       input logic [31:0] er, input logic eo, input logic ei);
        drive(ta, tb, ts, er, eo, ei);
        @(posedge clk);
        #1 start = 1'b0;
        wait_empty(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vec_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        reset = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 32'h0);
        chk("reset_ctl", {28'd0, busy, done, overflow, invalid}, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // arithmetic vectors
        run(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0); // 1+2
        run(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0); // x-x
        run(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0); // -2+1
        run(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0); // tie to even
        run(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0); // above tie
        run(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0); // tie, odd lsb
        run(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 1'b0); // round carry
        run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0); // overflow
        run(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1); // Inf-Inf
        run(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1); // NaN in
        run(32'hFF800000, 32'h7F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1); // -Inf+Inf
        run(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0); // Inf+1
        run(32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 1'b0); // 1-(-Inf)
        run(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0); // 1-2
        run(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0); // 3-1
        run(32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0); // 0+1
        run(32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0); // denormal flush
        run(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0); // 1+(-1)
        run(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b0); // underflow
        run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0); // 1+1

        // start pulses while busy are ignored
        d0 = done_cnt;
        drive(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_in_op", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 begin start = 1'b1; a = 32'h7FC00000; b = 32'h0; end
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 begin start = 1'b1; a = 32'h7F7FFFFF; b = 32'h7F7FFFFF; end
        @(posedge clk);
        #1 start = 1'b0;
        wait_empty(20);
        repeat (8) @(posedge clk);
        #1;
        chk("single_done", 32'(done_cnt - d0), 32'd1);

        // back-to-back: second start issued in the done cycle
        drive(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        chk("b2b_first_done_seen", {31'd0, done}, 32'd1);
        drive(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_empty(20);

        // reset in the middle of an operation
        drive(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_result", result, 32'h0);
        chk("abort_ctl", {28'd0, busy, done, overflow, invalid}, 32'd0);
        sb.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);

        // normal operation resumes
        run(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
